// File: rtl/seq_pkg.sv
// Shared types and bus-field constants for the routine sequencer.
// Also holds the helper that picks the next routine index.
package seq_pkg;

  typedef enum logic [1:0] {S_START, S_RUN, S_GAP} state_t;

  localparam int unsigned DONE_BIT  = 46;
  localparam int unsigned LED_HI    = 45;
  localparam int unsigned LED_LO    = 28;
  localparam int unsigned HEX_HI    = 27;
  localparam int unsigned HEX_LO    = 0;
  localparam int unsigned BUS_W     = 47;
  localparam int unsigned LED_W     = LED_HI - LED_LO + 1;
  localparam int unsigned HEX_W     = HEX_HI - HEX_LO + 1;
  localparam int unsigned IDX_W     = 2;

  localparam logic [HEX_W-1:0] HEX_BLANK = 28'hFFFFFFF;

  // One routine's output bus, MSB first: done, LEDs, HEX3..HEX0.
  typedef struct packed {
    logic             done;
    logic [LED_W-1:0] led;
    logic [HEX_W-1:0] hex;
  } routine_bus_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i,
                                                input int unsigned      n);
    return (32'(i) == n - 1) ? IDX_W'(0) : i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/routine_sequencer_if.sv
// Routine buses in, per-routine resets and display outputs back out.
interface routine_sequencer_if #(
  parameter int unsigned NUM_ROUTINES = 4
);
  import seq_pkg::*;

  logic [BUS_W*NUM_ROUTINES-1:0] RoutineBus;
  logic [NUM_ROUTINES-1:0]       RoutineReset;
  logic                          Skip;
  logic                          Loop;
  logic [LED_W-1:0]              Ledr;
  logic [HEX_W-1:0]              Hex;
  logic [IDX_W-1:0]              ActiveIdx;
  logic                          Fault;

  modport master (
    output RoutineBus, Skip, Loop,
    input  RoutineReset, Ledr, Hex, ActiveIdx, Fault
  );

  modport slave (
    input  RoutineBus, Skip, Loop,
    output RoutineReset, Ledr, Hex, ActiveIdx, Fault
  );

endinterface

// File: rtl/seq_timer.sv
// Up-counter shared by the RUN watchdog and the GAP blanking interval.
module seq_timer #(
  parameter int unsigned W = 6
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + W'(1);
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/routine_sequencer.sv
// Runs one light routine at a time, holding the rest in reset, with a
// blanked gap between routines and a watchdog on each run.
module routine_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_ROUTINES = 4,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter int unsigned MAX_CYCLES   = 64
) (
  input  logic                Clock,
  input  logic                Reset,
  routine_sequencer_if.slave  rs
);

  localparam int unsigned CNT_MAX = (MAX_CYCLES > GAP_CYCLES) ? MAX_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    done_prev;
  logic [LED_W-1:0]        ledr_q;
  logic [HEX_W-1:0]        hex_q;
  logic [NUM_ROUTINES-1:0] rr_q;
  logic                    fault_q;

  routine_bus_t            cur;
  logic [NUM_ROUTINES-1:0] run_mask;
  logic [CNT_W-1:0]        tc_val;
  logic                    tc;
  logic                    rise;
  logic                    run_exit;
  logic                    gap_end;
  logic                    t_clear;
  logic                    t_enable;

  // Slice the active routine's bus out of the concatenated input.
  always_comb begin
    cur = '0;
    for (int k = 0; k < int'(NUM_ROUTINES); k++) begin
      if (idx == IDX_W'(k)) cur = rs.RoutineBus[k*BUS_W +: BUS_W];
    end
  end

  always_comb begin
    run_mask = '1;
    for (int k = 0; k < int'(NUM_ROUTINES); k++) begin
      if (idx == IDX_W'(k)) run_mask[k] = 1'b0;
    end
  end

  assign rise     = cur.done & ~done_prev;
  assign run_exit = (state == S_RUN) & (rs.Skip | rise | tc);
  assign gap_end  = (state == S_GAP) & tc;
  assign tc_val   = (state == S_GAP) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(MAX_CYCLES - 1);
  assign t_clear  = (state == S_START) | run_exit | gap_end;
  assign t_enable = (state != S_START);

  seq_timer #(.W(CNT_W)) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (t_clear),
    .enable (t_enable),
    .tc_val (tc_val),
    .tc     (tc)
  );

  // Outputs default to blank; only a RUN cycle that stays in RUN shows the routine.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= S_START;
      idx       <= '0;
      done_prev <= 1'b0;
      ledr_q    <= '0;
      hex_q     <= HEX_BLANK;
      rr_q      <= '1;
      fault_q   <= 1'b0;
    end else begin
      ledr_q <= '0;
      hex_q  <= HEX_BLANK;
      case (state)
        S_START: begin
          done_prev <= cur.done;
          rr_q      <= run_mask;
          state     <= S_RUN;
        end
        S_RUN: begin
          done_prev <= cur.done;
          if (run_exit) begin
            state <= S_GAP;
            rr_q  <= '1;
            if (tc && !rs.Skip && !rise) fault_q <= 1'b1;
          end else begin
            ledr_q <= cur.led;
            hex_q  <= cur.hex;
          end
        end
        S_GAP: begin
          if (tc) begin
            state <= S_START;
            if (!rs.Loop) idx <= next_idx(idx, NUM_ROUTINES);
          end
        end
        default: state <= S_START;
      endcase
    end
  end

  assign rs.Ledr         = ledr_q;
  assign rs.Hex          = hex_q;
  assign rs.RoutineReset = rr_q;
  assign rs.ActiveIdx    = idx;
  assign rs.Fault        = fault_q;

endmodule
